// File: rtl/sbio_tx_scheduler.sv
// sbio_tx_scheduler
//   Shares the serial TX link between three sources (OUT audio samples, READ
//   requests, SCAN words). One winner per frame is serialised as
//   START / HEADER / PAYLOAD onto tx_pins. A READ cap and an OUT credit budget
//   throttle the respective sources.
// Ports
//   clk, reset_n                       clock, async active-low reset
//   out_valid/out_data/out_ready       OUT handshake (ready is a 1-cycle comb pulse)
//   read_valid/read_data/read_ready    READ handshake (payload = address)
//   scan_valid/scan_data/scan_ready    SCAN handshake
//   read_resp                          one READ answered, frees a slot
//   credit_load/credit_value           reload OUT credits
//   tx_pins                            registered serial output
//   busy                               frame in progress
//   reads_pending                      outstanding READ count
//   out_credits                        remaining OUT credits
//   resp_error                         sticky: read_resp with nothing outstanding
module sbio_tx_scheduler #(
  parameter int unsigned IO_BITS        = 2,
  parameter int unsigned PAYLOAD_CYCLES = 8,
  parameter int unsigned MAX_READS      = 2,
  parameter int unsigned CREDIT_BITS    = 4,
  parameter int unsigned CREDITS_INIT   = 3,
  parameter int unsigned HDR_SCAN       = 0,
  parameter int unsigned HDR_OUT        = 1,
  parameter int unsigned HDR_READ       = 2
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                out_valid,
  input  logic [PAYLOAD_CYCLES*IO_BITS-1:0]   out_data,
  output logic                                out_ready,
  input  logic                                read_valid,
  input  logic [PAYLOAD_CYCLES*IO_BITS-1:0]   read_data,
  output logic                                read_ready,
  input  logic                                scan_valid,
  input  logic [PAYLOAD_CYCLES*IO_BITS-1:0]   scan_data,
  output logic                                scan_ready,
  input  logic                                read_resp,
  input  logic                                credit_load,
  input  logic [CREDIT_BITS-1:0]              credit_value,
  output logic [IO_BITS-1:0]                  tx_pins,
  output logic                                busy,
  output logic [2:0]                          reads_pending,
  output logic [CREDIT_BITS-1:0]              out_credits,
  output logic                                resp_error
);

  localparam int unsigned WORD_SIZE = PAYLOAD_CYCLES * IO_BITS;
  localparam int unsigned CNT_W     = (PAYLOAD_CYCLES > 1) ? $clog2(PAYLOAD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAYLOAD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_HEADER  = 2'd2,
    S_PAYLOAD = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WORD_SIZE-1:0]   shift_q, shift_d;
  logic [IO_BITS-1:0]     hdr_q, hdr_d;
  logic [IO_BITS-1:0]     tx_pins_q, tx_pins_d;
  logic                   busy_q, busy_d;
  // 1: READ wins the next READ/SCAN tie. Reset treats SCAN as last served.
  logic                   rr_read_q, rr_read_d;
  logic [2:0]             reads_pending_q, reads_pending_d;
  logic [CREDIT_BITS-1:0] out_credits_q, out_credits_d;
  logic                   resp_error_q, resp_error_d;

  logic out_elig, read_elig, scan_elig, arb_en;
  logic grant_out, grant_read, grant_scan, grant_any;

  // Eligibility and arbitration: OUT fixed priority, READ/SCAN round-robin
  always_comb begin
    out_elig   = out_valid && (out_credits_q != '0);
    read_elig  = read_valid && (reads_pending_q < 3'(MAX_READS));
    scan_elig  = scan_valid;
    arb_en     = (state_q == S_IDLE) || ((state_q == S_PAYLOAD) && (cnt_q == CNT_LAST));
    grant_out  = arb_en && out_elig;
    grant_read = arb_en && !out_elig && read_elig && (!scan_elig || rr_read_q);
    grant_scan = arb_en && !out_elig && scan_elig && (!read_elig || !rr_read_q);
    grant_any  = grant_out || grant_read || grant_scan;
  end

  // Ready is the grant itself; held low while reset is asserted
  assign out_ready  = grant_out  & reset_n;
  assign read_ready = grant_read & reset_n;
  assign scan_ready = grant_scan & reset_n;

  // Next-state, serialiser and flow-control counters
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    shift_d         = shift_q;
    hdr_d           = hdr_q;
    tx_pins_d       = '0;
    rr_read_d       = rr_read_q;
    reads_pending_d = reads_pending_q;
    out_credits_d   = out_credits_q;
    resp_error_d    = resp_error_q;

    // tx_pins_d is the symbol the link carries during the following cycle
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          state_d   = S_START;
          tx_pins_d = IO_BITS'(1);
        end
      end
      S_START: begin
        state_d   = S_HEADER;
        tx_pins_d = hdr_q;
      end
      S_HEADER: begin
        state_d   = S_PAYLOAD;
        cnt_d     = '0;
        tx_pins_d = shift_q[IO_BITS-1:0];
        shift_d   = shift_q >> IO_BITS;
      end
      S_PAYLOAD: begin
        if (cnt_q == CNT_LAST) begin
          if (grant_any) begin
            state_d   = S_START;
            tx_pins_d = IO_BITS'(1);
          end else begin
            state_d   = S_IDLE;
          end
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          tx_pins_d = shift_q[IO_BITS-1:0];
          shift_d   = shift_q >> IO_BITS;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Capture the winner's word and header code
    if (grant_out) begin
      shift_d = out_data;
      hdr_d   = IO_BITS'(HDR_OUT);
    end else if (grant_read) begin
      shift_d   = read_data;
      hdr_d     = IO_BITS'(HDR_READ);
      rr_read_d = 1'b0;
    end else if (grant_scan) begin
      shift_d   = scan_data;
      hdr_d     = IO_BITS'(HDR_SCAN);
      rr_read_d = 1'b1;
    end

    // Outstanding READs; a simultaneous grant and response cancel out
    if (grant_read && !read_resp) begin
      reads_pending_d = reads_pending_q + 3'd1;
    end else if (!grant_read && read_resp) begin
      if (reads_pending_q == '0) begin
        resp_error_d = 1'b1;
      end else begin
        reads_pending_d = reads_pending_q - 3'd1;
      end
    end

    // OUT credits; a load in the grant cycle already pays for that grant
    if (credit_load) begin
      out_credits_d = (grant_out && (credit_value != '0)) ? credit_value - CREDIT_BITS'(1)
                                                          : credit_value;
    end else if (grant_out) begin
      out_credits_d = out_credits_q - CREDIT_BITS'(1);
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      shift_q         <= '0;
      hdr_q           <= '0;
      tx_pins_q       <= '0;
      busy_q          <= 1'b0;
      rr_read_q       <= 1'b1;
      reads_pending_q <= '0;
      out_credits_q   <= CREDIT_BITS'(CREDITS_INIT);
      resp_error_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      shift_q         <= shift_d;
      hdr_q           <= hdr_d;
      tx_pins_q       <= tx_pins_d;
      busy_q          <= busy_d;
      rr_read_q       <= rr_read_d;
      reads_pending_q <= reads_pending_d;
      out_credits_q   <= out_credits_d;
      resp_error_q    <= resp_error_d;
    end
  end

  assign tx_pins       = tx_pins_q;
  assign busy          = busy_q;
  assign reads_pending = reads_pending_q;
  assign out_credits   = out_credits_q;
  assign resp_error    = resp_error_q;

endmodule

// File: tb/tb_sbio_tx_scheduler.sv
// Testbench for sbio_tx_scheduler: directed scenarios plus a randomized run
// checked against a frame-level reference model (queue of expected pin symbols).
module tb_sbio_tx_scheduler;

  localparam int unsigned PAYLOAD_CYCLES = 8;
  localparam int unsigned MAX_READS      = 2;
  localparam int unsigned CREDITS_INIT   = 3;
  localparam int SRC_NONE = 0;
  localparam int SRC_OUT  = 1;
  localparam int SRC_READ = 2;
  localparam int SRC_SCAN = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        out_valid, read_valid, scan_valid;
  logic [15:0] out_data, read_data, scan_data;
  logic        out_ready, read_ready, scan_ready;
  logic        read_resp, credit_load;
  logic [3:0]  credit_value;
  logic [1:0]  tx_pins;
  logic        busy;
  logic [2:0]  reads_pending;
  logic [3:0]  out_credits;
  logic        resp_error;

  int checks   = 0;
  int failures = 0;

  sbio_tx_scheduler dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .read_valid   (read_valid),
    .read_data    (read_data),
    .read_ready   (read_ready),
    .scan_valid   (scan_valid),
    .scan_data    (scan_data),
    .scan_ready   (scan_ready),
    .read_resp    (read_resp),
    .credit_load  (credit_load),
    .credit_value (credit_value),
    .tx_pins      (tx_pins),
    .busy         (busy),
    .reads_pending(reads_pending),
    .out_credits  (out_credits),
    .resp_error   (resp_error)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    out_valid = 1'b0; read_valid = 1'b0; scan_valid = 1'b0;
    out_data = '0; read_data = '0; scan_data = '0;
    read_resp = 1'b0; credit_load = 1'b0; credit_value = '0;
  endtask

  // Leaves the bench in cycle 0 after release (inputs may be set for that cycle)
  task automatic apply_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    scan_valid = 1'b1;
    out_valid  = 1'b1;
    @(negedge clk);
    checks++; if (tx_pins !== 2'd0) begin failures++; $display("FAIL rst_tx got %0d exp 0", tx_pins); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %0b exp 0", busy); end
    checks++; if ({out_ready, read_ready, scan_ready} !== 3'b000) begin failures++; $display("FAIL rst_ready got %b exp 000", {out_ready, read_ready, scan_ready}); end
    checks++; if (reads_pending !== 3'd0) begin failures++; $display("FAIL rst_pending got %0d exp 0", reads_pending); end
    checks++; if (out_credits !== 4'(CREDITS_INIT)) begin failures++; $display("FAIL rst_credits got %0d exp %0d", out_credits, CREDITS_INIT); end
    checks++; if (resp_error !== 1'b0) begin failures++; $display("FAIL rst_resp_error got %0b exp 0", resp_error); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_scan_frame();
    int exp_pins[10] = '{1, 0, 3, 0, 0, 3, 1, 1, 2, 2};
    apply_reset();
    scan_valid = 1'b1;
    scan_data  = 16'hA5C3;
    to_sample();
    checks++; if (scan_ready !== 1'b1) begin failures++; $display("FAIL t1_scan_ready got %0b exp 1", scan_ready); end
    checks++; if ({out_ready, read_ready} !== 2'b00) begin failures++; $display("FAIL t1_other_ready got %b exp 00", {out_ready, read_ready}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t1_busy_c0 got %0b exp 0", busy); end
    next_cycle();
    scan_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      to_sample();
      checks++; if (tx_pins !== 2'(exp_pins[i])) begin failures++; $display("FAIL t1_tx[%0d] got %0d exp %0d", i, tx_pins, exp_pins[i]); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy[%0d] got %0b exp 1", i, busy); end
      next_cycle();
    end
    to_sample();
    checks++; if (busy !== 1'b0 || tx_pins !== 2'd0) begin failures++; $display("FAIL t1_end got busy=%0b tx=%0d exp busy=0 tx=0", busy, tx_pins); end
  endtask

  task automatic test_back_to_back();
    int order[$];
    int gcyc[$];
    int tx_log[40];
    int busy_cnt, first_busy, last_busy, multi;
    bit so, sr, ss;
    logic [15:0] rd;
    busy_cnt = 0; first_busy = -1; last_busy = -1; multi = 0;
    apply_reset();
    rd = 16'($urandom);
    out_valid = 1'b1;  out_data  = 16'($urandom);
    read_valid = 1'b1; read_data = rd;
    scan_valid = 1'b1; scan_data = 16'($urandom);
    for (int c = 0; c < 40; c++) begin
      to_sample();
      so = out_ready; sr = read_ready; ss = scan_ready;
      if (int'(so) + int'(sr) + int'(ss) > 1) multi++;
      if (so) begin order.push_back(SRC_OUT);  gcyc.push_back(c); end
      if (sr) begin order.push_back(SRC_READ); gcyc.push_back(c); end
      if (ss) begin order.push_back(SRC_SCAN); gcyc.push_back(c); end
      tx_log[c] = int'(tx_pins);
      if (busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = c;
        last_busy = c;
      end
      next_cycle();
      if (so) out_valid = 1'b0;
      if (sr) read_valid = 1'b0;
      if (ss) scan_valid = 1'b0;
    end
    checks++; if (order.size() != 3) begin failures++; $display("FAIL t2_grants got %0d exp 3", order.size()); end
    else begin
      checks++; if (order[0] != SRC_OUT || order[1] != SRC_READ || order[2] != SRC_SCAN) begin failures++; $display("FAIL t2_order got %0d,%0d,%0d exp %0d,%0d,%0d", order[0], order[1], order[2], SRC_OUT, SRC_READ, SRC_SCAN); end
      checks++; if (gcyc[0] != 0 || gcyc[1] != 10 || gcyc[2] != 20) begin failures++; $display("FAIL t2_grant_cycles got %0d,%0d,%0d exp 0,10,20", gcyc[0], gcyc[1], gcyc[2]); end
    end
    checks++; if (multi != 0) begin failures++; $display("FAIL t2_multi_ready got %0d exp 0", multi); end
    checks++; if (busy_cnt != 30) begin failures++; $display("FAIL t2_busy_cycles got %0d exp 30", busy_cnt); end
    checks++; if (last_busy - first_busy + 1 != 30) begin failures++; $display("FAIL t2_busy_span got %0d exp 30", last_busy - first_busy + 1); end
    checks++; if (tx_log[1] != 1 || tx_log[2] != 1) begin failures++; $display("FAIL t2_out_hdr got %0d,%0d exp 1,1", tx_log[1], tx_log[2]); end
    checks++; if (tx_log[11] != 1 || tx_log[12] != 2) begin failures++; $display("FAIL t2_read_hdr got %0d,%0d exp 1,2", tx_log[11], tx_log[12]); end
    checks++; if (tx_log[21] != 1 || tx_log[22] != 0) begin failures++; $display("FAIL t2_scan_hdr got %0d,%0d exp 1,0", tx_log[21], tx_log[22]); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (tx_log[13 + k] != int'((rd >> (2 * k)) & 16'h3)) begin failures++; $display("FAIL t2_read_payload[%0d] got %0d exp %0d", k, tx_log[13 + k], int'((rd >> (2 * k)) & 16'h3)); end
    end
  endtask

  task automatic test_read_cap();
    int gcyc[$];
    apply_reset();
    read_valid = 1'b1;
    read_data  = 16'($urandom);
    for (int c = 0; c < 30; c++) begin
      to_sample();
      if (read_ready) gcyc.push_back(c);
      next_cycle();
    end
    checks++; if (gcyc.size() != 2) begin failures++; $display("FAIL t3_grants got %0d exp 2", gcyc.size()); end
    else begin
      checks++; if (gcyc[0] != 0 || gcyc[1] != 10) begin failures++; $display("FAIL t3_grant_cycles got %0d,%0d exp 0,10", gcyc[0], gcyc[1]); end
    end
    read_resp = 1'b1;
    to_sample();
    checks++; if (reads_pending !== 3'd2) begin failures++; $display("FAIL t3_pending_cap got %0d exp 2", reads_pending); end
    checks++; if (read_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL t3_capped got ready=%0b busy=%0b exp 0,0", read_ready, busy); end
    next_cycle();
    read_resp = 1'b0;
    to_sample();
    checks++; if (read_ready !== 1'b1) begin failures++; $display("FAIL t3_regrant got %0b exp 1", read_ready); end
    checks++; if (reads_pending !== 3'd1) begin failures++; $display("FAIL t3_pending_dec got %0d exp 1", reads_pending); end
    next_cycle();
    read_valid = 1'b0;
    to_sample();
    checks++; if (busy !== 1'b1 || tx_pins !== 2'd1) begin failures++; $display("FAIL t3_start got busy=%0b tx=%0d exp 1,1", busy, tx_pins); end
    checks++; if (reads_pending !== 3'd2) begin failures++; $display("FAIL t3_pending_inc got %0d exp 2", reads_pending); end
  endtask

  task automatic test_credits();
    int gcyc[$];
    apply_reset();
    credit_load  = 1'b1;
    credit_value = 4'd1;
    next_cycle();
    credit_load = 1'b0;
    out_valid   = 1'b1;
    out_data    = 16'($urandom);
    for (int c = 1; c < 30; c++) begin
      to_sample();
      if (c == 1) begin
        checks++; if (out_credits !== 4'd1) begin failures++; $display("FAIL t4_loaded got %0d exp 1", out_credits); end
      end
      if (out_ready) gcyc.push_back(c);
      next_cycle();
    end
    checks++; if (gcyc.size() != 1 || gcyc[0] != 1) begin failures++; $display("FAIL t4_first_grants got %0d grants exp 1 at cycle 1", gcyc.size()); end
    checks++; if (out_credits !== 4'd0) begin failures++; $display("FAIL t4_exhausted got %0d exp 0", out_credits); end
    gcyc.delete();
    credit_load  = 1'b1;
    credit_value = 4'd2;
    to_sample();
    checks++; if (out_ready !== 1'b0) begin failures++; $display("FAIL t4_no_credit_grant got %0b exp 0", out_ready); end
    next_cycle();
    credit_load = 1'b0;
    for (int c = 31; c < 61; c++) begin
      to_sample();
      if (out_ready) gcyc.push_back(c);
      next_cycle();
    end
    checks++; if (gcyc.size() != 2) begin failures++; $display("FAIL t4_reload_grants got %0d exp 2", gcyc.size()); end
    else begin
      checks++; if (gcyc[0] != 31 || gcyc[1] != 41) begin failures++; $display("FAIL t4_reload_cycles got %0d,%0d exp 31,41", gcyc[0], gcyc[1]); end
    end
    to_sample();
    checks++; if (out_credits !== 4'd0) begin failures++; $display("FAIL t4_final_credits got %0d exp 0", out_credits); end
    next_cycle();
    out_valid = 1'b0;
  endtask

  task automatic test_resp_error();
    apply_reset();
    read_resp = 1'b1;
    to_sample();
    checks++; if (resp_error !== 1'b0) begin failures++; $display("FAIL t5_err_before got %0b exp 0", resp_error); end
    next_cycle();
    read_resp  = 1'b0;
    read_valid = 1'b1;
    read_data  = 16'($urandom);
    to_sample();
    checks++; if (resp_error !== 1'b1) begin failures++; $display("FAIL t5_err_set got %0b exp 1", resp_error); end
    checks++; if (reads_pending !== 3'd0) begin failures++; $display("FAIL t5_pending_zero got %0d exp 0", reads_pending); end
    checks++; if (read_ready !== 1'b1) begin failures++; $display("FAIL t5_read_grant got %0b exp 1", read_ready); end
    next_cycle();
    read_valid = 1'b0;
    repeat (9) next_cycle();
    read_valid = 1'b1;
    read_resp  = 1'b1;
    to_sample();
    checks++; if (read_ready !== 1'b1) begin failures++; $display("FAIL t5_b2b_grant got %0b exp 1", read_ready); end
    checks++; if (reads_pending !== 3'd1) begin failures++; $display("FAIL t5_pending_one got %0d exp 1", reads_pending); end
    next_cycle();
    read_valid = 1'b0;
    read_resp  = 1'b0;
    to_sample();
    checks++; if (reads_pending !== 3'd1) begin failures++; $display("FAIL t5_pending_same got %0d exp 1", reads_pending); end
    checks++; if (resp_error !== 1'b1) begin failures++; $display("FAIL t5_err_sticky got %0b exp 1", resp_error); end
    checks++; if (tx_pins !== 2'd1 || busy !== 1'b1) begin failures++; $display("FAIL t5_b2b_start got tx=%0d busy=%0b exp 1,1", tx_pins, busy); end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    scan_valid = 1'b1;
    scan_data  = 16'hFFFF;
    to_sample();
    checks++; if (scan_ready !== 1'b1) begin failures++; $display("FAIL t6_scan_grant got %0b exp 1", scan_ready); end
    next_cycle();
    scan_valid = 1'b0;
    out_valid  = 1'b1;
    out_data   = 16'($urandom);
    repeat (6) next_cycle();
    to_sample();
    checks++; if (tx_pins !== 2'd3 || busy !== 1'b1) begin failures++; $display("FAIL t6_mid_payload got tx=%0d busy=%0b exp 3,1", tx_pins, busy); end
    reset_n = 1'b0;
    #1;
    checks++; if (tx_pins !== 2'd0 || busy !== 1'b0) begin failures++; $display("FAIL t6_async_clear got tx=%0d busy=%0b exp 0,0", tx_pins, busy); end
    checks++; if (out_ready !== 1'b0) begin failures++; $display("FAIL t6_ready_in_reset got %0b exp 0", out_ready); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    to_sample();
    checks++; if (out_ready !== 1'b1) begin failures++; $display("FAIL t6_regrant got %0b exp 1", out_ready); end
    next_cycle();
    out_valid = 1'b0;
    to_sample();
    checks++; if (tx_pins !== 2'd1 || busy !== 1'b1) begin failures++; $display("FAIL t6_start got tx=%0d busy=%0b exp 1,1", tx_pins, busy); end
    checks++; if (out_credits !== 4'(CREDITS_INIT - 1)) begin failures++; $display("FAIL t6_credits got %0d exp %0d", out_credits, CREDITS_INIT - 1); end
    next_cycle();
    to_sample();
    checks++; if (tx_pins !== 2'd1) begin failures++; $display("FAIL t6_hdr got %0d exp 1", tx_pins); end
  endtask

  // Randomized traffic against a frame-level model: a queue of the symbols the
  // link must carry, refilled with a whole frame whenever it runs dry.
  task automatic test_random();
    int          pins[$];
    int          m_pend, m_cred, g, last_g, e_tx, hdr;
    bit          m_err, m_read_next, e_busy, oe, re, se;
    logic [15:0] w;
    apply_reset();
    m_pend = 0; m_cred = int'(CREDITS_INIT); m_err = 1'b0; m_read_next = 1'b1;
    last_g = SRC_NONE;
    for (int c = 0; c < 3000; c++) begin
      if (last_g == SRC_OUT) begin out_valid = ($urandom_range(0, 1) == 1); out_data = 16'($urandom); end
      else if (!out_valid) begin if ($urandom_range(0, 3) == 0) begin out_valid = 1'b1; out_data = 16'($urandom); end end
      else if ($urandom_range(0, 39) == 0) out_valid = 1'b0;
      if (last_g == SRC_READ) begin read_valid = ($urandom_range(0, 1) == 1); read_data = 16'($urandom); end
      else if (!read_valid) begin if ($urandom_range(0, 3) == 0) begin read_valid = 1'b1; read_data = 16'($urandom); end end
      else if ($urandom_range(0, 39) == 0) read_valid = 1'b0;
      if (last_g == SRC_SCAN) begin scan_valid = ($urandom_range(0, 1) == 1); scan_data = 16'($urandom); end
      else if (!scan_valid) begin if ($urandom_range(0, 3) == 0) begin scan_valid = 1'b1; scan_data = 16'($urandom); end end
      else if ($urandom_range(0, 39) == 0) scan_valid = 1'b0;
      read_resp    = (m_pend > 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 199) == 0);
      credit_load  = ($urandom_range(0, 29) == 0);
      credit_value = 4'($urandom_range(0, 6));

      to_sample();
      e_busy = (pins.size() != 0);
      e_tx   = e_busy ? pins.pop_front() : 0;
      checks++; if (tx_pins !== 2'(e_tx)) begin failures++; $display("FAIL rnd_tx cycle %0d got %0d exp %0d", c, tx_pins, e_tx); end
      checks++; if (busy !== e_busy) begin failures++; $display("FAIL rnd_busy cycle %0d got %0b exp %0b", c, busy, e_busy); end
      checks++; if (reads_pending !== 3'(m_pend)) begin failures++; $display("FAIL rnd_pending cycle %0d got %0d exp %0d", c, reads_pending, m_pend); end
      checks++; if (out_credits !== 4'(m_cred)) begin failures++; $display("FAIL rnd_credits cycle %0d got %0d exp %0d", c, out_credits, m_cred); end
      checks++; if (resp_error !== m_err) begin failures++; $display("FAIL rnd_resp_error cycle %0d got %0b exp %0b", c, resp_error, m_err); end

      g = SRC_NONE;
      if (pins.size() == 0) begin
        oe = out_valid && (m_cred != 0);
        re = read_valid && (m_pend < int'(MAX_READS));
        se = scan_valid;
        if (oe) g = SRC_OUT;
        else if (re && se) g = m_read_next ? SRC_READ : SRC_SCAN;
        else if (re) g = SRC_READ;
        else if (se) g = SRC_SCAN;
        if (g != SRC_NONE) begin
          w   = (g == SRC_OUT) ? out_data : (g == SRC_READ) ? read_data : scan_data;
          hdr = (g == SRC_OUT) ? 1 : (g == SRC_READ) ? 2 : 0;
          pins.push_back(1);
          pins.push_back(hdr);
          for (int k = 0; k < int'(PAYLOAD_CYCLES); k++) pins.push_back(int'((w >> (2 * k)) & 16'h3));
        end
      end
      checks++; if ({out_ready, read_ready, scan_ready} !== {g == SRC_OUT, g == SRC_READ, g == SRC_SCAN}) begin
        failures++; $display("FAIL rnd_ready cycle %0d got %b exp %b", c, {out_ready, read_ready, scan_ready}, {g == SRC_OUT, g == SRC_READ, g == SRC_SCAN});
      end

      if (g == SRC_READ) m_read_next = 1'b0;
      if (g == SRC_SCAN) m_read_next = 1'b1;
      if (g == SRC_READ && !read_resp) m_pend++;
      else if (g != SRC_READ && read_resp) begin
        if (m_pend == 0) m_err = 1'b1;
        else m_pend--;
      end
      if (credit_load) m_cred = (g == SRC_OUT && credit_value != 0) ? int'(credit_value) - 1 : int'(credit_value);
      else if (g == SRC_OUT) m_cred--;
      last_g = g;
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_scan_frame();
    test_back_to_back();
    test_read_cap();
    test_credits();
    test_resp_error();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
